// File: rtl/acf_readout_scheduler.sv
// rtl/acf_readout_scheduler.sv - acquisition timer and multi-channel ACF readout sequencer
module acf_readout_scheduler #(
    parameter int NUM_CH    = 4,
    parameter int NUM_BINS  = 20,
    parameter int BIN_SIZE  = 8,
    parameter int CNTR_SIZE = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                            CLK,
    input  logic                            rst_n,
    input  logic                            acq_en,
    input  logic                            tick,
    input  logic [31:0]                     t_acq,
    input  logic                            err_clr,
    input  logic [15:0]                     fifo_free,
    input  logic [NUM_CH*(NUM_BINS+33)-1:0] ch_acfEl,
    input  logic [NUM_CH-1:0]               ch_wrEn,
    output logic [NUM_CH-1:0]               ch_initTx,
    output logic                            ch_CE,
    output logic [CNTR_SIZE-1:0]            presentTime,
    output logic [NUM_BINS+32:0]            fifo_din,
    output logic                            fifo_wrEn,
    output logic [31:0]                     frame_cnt,
    output logic                            busy,
    output logic                            frame_done,
    output logic [2:0]                      err
);

    localparam int W     = NUM_BINS + 33;
    localparam int WPC   = BIN_SIZE * (NUM_BINS + 1) + 1;
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WC_W  = $clog2(WPC + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [16:0]      SPACE_NEED = 17'(WPC + 1);
    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(NUM_CH - 1);
    localparam logic [WC_W-1:0]  LAST_WORD  = WC_W'(WPC - 1);
    localparam logic [TO_W-1:0]  LAST_IDLE  = TO_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACQ    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_HDR    = 3'd3;
    localparam logic [2:0] S_INIT   = 3'd4;
    localparam logic [2:0] S_STREAM = 3'd5;
    localparam logic [2:0] S_NEXT   = 3'd6;

    logic [2:0]       state;
    logic [31:0]      pcnt;
    logic [SEL_W-1:0] sel;
    logic [WC_W-1:0]  wcnt;
    logic [TO_W-1:0]  idle;
    logic [W-1:0]     word_q;
    logic             word_v;

    logic             acq_rise;
    logic [31:0]      pcnt_last;
    logic             period_end;
    logic             wr_sel;
    logic             to_hit;
    logic             stray;
    logic [W-1:0]     sel_word;
    logic [W-1:0]     header;

    // ch_CE is acq_en delayed by one cycle, so it doubles as the edge-detect history
    assign acq_rise   = acq_en & ~ch_CE;
    assign pcnt_last  = (t_acq == 32'd0) ? 32'd0 : t_acq - 32'd1;
    // >= keeps the period bounded if t_acq is lowered mid-period
    assign period_end = acq_en & ~acq_rise & tick & (pcnt >= pcnt_last);

    assign wr_sel = (state == S_STREAM) & ch_wrEn[sel];
    assign to_hit = (state == S_STREAM) & ~ch_wrEn[sel] & (idle == LAST_IDLE);

    always_comb begin
        stray    = 1'b0;
        sel_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_wrEn[c] && !(state == S_STREAM && sel == SEL_W'(c)))
                stray = 1'b1;
            if (sel == SEL_W'(c))
                sel_word = ch_acfEl[c*W +: W];
        end
    end

    assign header     = W'({frame_cnt[15:0], 8'(sel)});
    assign busy       = (state >= S_WAIT) && (state <= S_NEXT);
    assign frame_done = (state == S_NEXT) && (sel == LAST_SEL);
    assign ch_initTx  = (state == S_INIT) ? (NUM_CH'(1) << sel) : '0;
    assign fifo_wrEn  = (state == S_HDR) | word_v;
    assign fifo_din   = (state == S_HDR) ? header : word_q;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            ch_CE       <= 1'b0;
            presentTime <= '0;
            pcnt        <= '0;
        end else begin
            ch_CE <= acq_en;
            if (acq_rise) begin
                presentTime <= '0;
                pcnt        <= '0;
            end else if (acq_en && tick) begin
                presentTime <= presentTime + 1'b1;
                pcnt        <= period_end ? 32'd0 : pcnt + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            err <= '0;
        end else if (err_clr) begin
            err <= '0;
        end else begin
            err <= err | {stray, to_hit, period_end & busy};
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sel       <= '0;
            wcnt      <= '0;
            idle      <= '0;
            word_q    <= '0;
            word_v    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            word_v <= 1'b0;
            if (wr_sel) begin
                word_q <= sel_word;
                word_v <= 1'b1;
            end
            case (state)
                S_IDLE, S_ACQ: begin
                    if (period_end) begin
                        sel   <= '0;
                        state <= S_WAIT;
                    end else begin
                        state <= acq_en ? S_ACQ : S_IDLE;
                    end
                end
                // channels cannot be throttled, so a full dump must fit before starting
                S_WAIT: if ({1'b0, fifo_free} >= SPACE_NEED) state <= S_HDR;
                S_HDR:  state <= S_INIT;
                S_INIT: begin
                    wcnt  <= '0;
                    idle  <= '0;
                    state <= S_STREAM;
                end
                S_STREAM: begin
                    if (wr_sel) begin
                        idle <= '0;
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == LAST_WORD) state <= S_NEXT;
                    end else if (to_hit) begin
                        state <= S_NEXT;
                    end else begin
                        idle <= idle + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (sel != LAST_SEL) begin
                        sel   <= sel + 1'b1;
                        state <= S_WAIT;
                    end else begin
                        frame_cnt <= frame_cnt + 32'd1;
                        state     <= acq_en ? S_ACQ : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
